// File: rtl/cpu_mem_if_pkg.sv
// Shared encodings for the CPU memory bridge: CPU mode codes and FSM states.
package cpu_mem_if_pkg;

    typedef enum logic [1:0] {
        CPU_STOP = 2'b00,
        CPU_LOAD = 2'b01,
        CPU_RUN  = 2'b10,
        CPU_STEP = 2'b11
    } cpustate_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR      = 3'd3,
        ST_LD_WR   = 3'd4,
        ST_DONE    = 3'd5
    } mem_state_e;

    function automatic logic cpu_active(input logic [1:0] cs);
        return (cs == CPU_RUN) || (cs == CPU_STEP);
    endfunction

endpackage

// File: rtl/cpu_mem_if.sv
// CPU-to-SRAM bridge: times CPU read/write strobes onto a synchronous SRAM and
// streams switch-entered program bytes into RAM while the CPU is in LOAD mode.
module cpu_mem_if
    import cpu_mem_if_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 8,
    parameter int RD_LAT = 1,
    parameter logic [AW-1:0] LOAD_BASE = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    cpustate,
    input  logic [AW-1:0] memaddr,
    input  logic [DW-1:0] data_out,
    input  logic          read,
    input  logic          write,
    output logic [DW-1:0] data_in,
    output logic          mem_ready,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_valid,
    output logic          ld_ready,
    output logic [AW-1:0] ld_count,
    output logic          err,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_ce,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

    mem_state_e    state_q;
    logic [2:0]    wait_q;
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ld_count_q;
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_wdata_q;
    logic [DW-1:0] data_in_q;
    logic          mem_ready_q;
    logic          ram_ce_q;
    logic          ram_we_q;
    logic          ld_ready_q;
    logic          err_q;
    logic          was_load_q;

    logic          in_load;
    logic          ld_enter;
    logic          ld_take;
    logic [AW-1:0] ld_ptr_d;

    assign in_load  = (cpustate == CPU_LOAD);
    // A LOAD entry and the first byte can coincide; the byte must land at LOAD_BASE.
    assign ld_enter = (state_q == ST_IDLE) && in_load && !was_load_q;
    assign ld_take  = (state_q == ST_IDLE) && ld_valid && ld_ready_q;
    assign ld_ptr_d = ld_enter ? LOAD_BASE : ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            ptr_q       <= LOAD_BASE;
            ld_count_q  <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            data_in_q   <= '0;
            mem_ready_q <= 1'b0;
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ld_ready_q  <= 1'b0;
            err_q       <= 1'b0;
            was_load_q  <= 1'b0;
        end else begin
            mem_ready_q <= 1'b0;
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ld_ready_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    was_load_q <= in_load;
                    if (ld_enter) begin
                        ptr_q      <= LOAD_BASE;
                        ld_count_q <= '0;
                    end
                    if (in_load && (read || write)) begin
                        err_q <= 1'b1;
                    end
                    if (ld_take) begin
                        ram_addr_q  <= ld_ptr_d;
                        ram_wdata_q <= ld_data;
                        ram_ce_q    <= 1'b1;
                        ram_we_q    <= 1'b1;
                        ptr_q       <= ld_ptr_d;
                        state_q     <= ST_LD_WR;
                    end else if (cpu_active(cpustate) && write) begin
                        ram_addr_q  <= memaddr;
                        ram_wdata_q <= data_out;
                        ram_ce_q    <= 1'b1;
                        ram_we_q    <= 1'b1;
                        state_q     <= ST_WR;
                        if (read) begin
                            err_q <= 1'b1;
                        end
                    end else if (cpu_active(cpustate) && read) begin
                        ram_addr_q <= memaddr;
                        ram_ce_q   <= 1'b1;
                        state_q    <= ST_RD;
                    end else begin
                        ld_ready_q <= in_load;
                    end
                end
                ST_RD: begin
                    wait_q  <= WAIT_INIT;
                    state_q <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (wait_q == 3'd0) begin
                        data_in_q   <= ram_rdata;
                        mem_ready_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        wait_q <= wait_q - 3'd1;
                    end
                end
                ST_WR: begin
                    mem_ready_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_LD_WR: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ld_count_q != {AW{1'b1}}) begin
                        ld_count_q <= ld_count_q + 1'b1;
                    end
                    ld_ready_q <= in_load;
                    state_q    <= ST_IDLE;
                end
                ST_DONE: begin
                    ld_ready_q <= in_load;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_in   = data_in_q;
    assign mem_ready = mem_ready_q;
    assign ld_ready  = ld_ready_q;
    assign ld_count  = ld_count_q;
    assign err       = err_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_ce    = ram_ce_q;
    assign ram_we    = ram_we_q;

endmodule

// File: tb/tb_cpu_mem_if.sv
// Bench for cpu_mem_if: behavioural SRAM plus a transaction-level memory model.
module tb_cpu_mem_if;

    localparam int AW     = 16;
    localparam int DW     = 8;
    localparam int RD_LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    cpustate = 2'b01;
    logic [AW-1:0] memaddr = '0;
    logic [DW-1:0] data_out = '0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [DW-1:0] data_in;
    logic          mem_ready;
    logic [DW-1:0] ld_data = '0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [AW-1:0] ld_count;
    logic          err;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_ce;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    cpu_mem_if #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .LOAD_BASE(16'h0000)) dut (
        .clk(clk), .rst(rst), .cpustate(cpustate), .memaddr(memaddr),
        .data_out(data_out), .read(read), .write(write), .data_in(data_in),
        .mem_ready(mem_ready), .ld_data(ld_data), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .ld_count(ld_count), .err(err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_ce(ram_ce),
        .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Power-up content of every byte; chosen so that 0x0012 holds 0xA5.
    function automatic logic [7:0] fill(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hB7;
    endfunction

    // Synchronous SRAM with RD_LAT-cycle read pipeline.
    logic [7:0] sram   [0:65535];
    bit         sram_w [0:65535];
    logic [7:0] rpipe  [0:RD_LAT-1];

    always @(posedge clk) begin
        if (ram_ce && ram_we) begin
            sram[ram_addr]   <= ram_wdata;
            sram_w[ram_addr] <= 1'b1;
        end
        for (int i = RD_LAT - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
        rpipe[0] <= (ram_ce && !ram_we) ? (sram_w[ram_addr] ? sram[ram_addr] : fill(ram_addr)) : 8'hEE;
    end
    assign ram_rdata = rpipe[RD_LAT-1];

    function automatic logic [7:0] sram_byte(input logic [15:0] a);
        return sram_w[a] ? sram[a] : fill(a);
    endfunction

    // Reference model: what RAM and the CPU-visible registers should hold.
    logic [7:0]  ref_mem [int];
    logic [7:0]  exp_din;
    logic        exp_err;
    logic [15:0] ref_ptr;
    int          ref_cnt;

    function automatic logic [7:0] ref_byte(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : fill(a);
    endfunction

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One CPU access from IDLE; called and returns on a falling edge.
    task automatic cpu_access(input logic is_wr, input logic both,
                              input logic [15:0] a, input logic [7:0] d);
        int lat;
        int ce_cnt;
        int we_cnt;
        lat = 0; ce_cnt = 0; we_cnt = 0;
        memaddr = a; data_out = d;
        write = is_wr; read = !is_wr || both;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            ce_cnt += int'(ram_ce);
            we_cnt += int'(ram_we);
            if (n == 2) begin
                check_eq("addr_hold", 32'(ram_addr), 32'(a));
                memaddr = 16'($urandom);
                data_out = 8'($urandom);
            end
            if (mem_ready) begin
                lat = n;
                break;
            end
        end
        read = 1'b0; write = 1'b0;
        if (is_wr) begin
            ref_mem[int'(a)] = d;
            if (both) exp_err = 1'b1;
        end else begin
            exp_din = ref_byte(a);
        end
        check_eq(is_wr ? "wr_latency" : "rd_latency", 32'(lat), is_wr ? 32'd2 : 32'(RD_LAT + 2));
        check_eq("ce_cycles", 32'(ce_cnt), 32'd1);
        check_eq("we_cycles", 32'(we_cnt), is_wr ? 32'd1 : 32'd0);
        check_eq("data_in", 32'(data_in), 32'(exp_din));
        check_eq("ram_byte", 32'(sram_byte(a)), 32'(ref_byte(a)));
        check_eq("err", 32'(err), 32'(exp_err));
        @(negedge clk);
        check_eq("ready_pulse", 32'(mem_ready), 32'd0);
    endtask

    // Offer one load byte with ld_valid held; returns on the falling edge after acceptance.
    task automatic load_byte(input logic [7:0] b, input int exp_wait);
        int waited;
        waited = 0;
        ld_data = b; ld_valid = 1'b1;
        while (!ld_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (exp_wait >= 0) check_eq("ld_gap", 32'(waited), 32'(exp_wait));
        @(negedge clk);
        check_eq("ld_ready_low", 32'(ld_ready), 32'd0);
        check_eq("ld_addr", 32'(ram_addr), 32'(ref_ptr));
        check_eq("ld_wdata", 32'(ram_wdata), 32'(b));
        check_eq("ld_we", 32'(ram_we), 32'd1);
        ref_mem[int'(ref_ptr)] = b;
        ref_ptr = ref_ptr + 16'd1;
        ref_cnt++;
    endtask

    task automatic enter_load();
        cpustate = 2'b01;
        ref_ptr = 16'h0000;
        ref_cnt = 0;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  d;
        int          hits;
        exp_din = 8'h00; exp_err = 1'b0; ref_ptr = 16'h0000; ref_cnt = 0;

        // Reset held with LOAD selected: everything idle, ld_ready still low.
        repeat (3) @(negedge clk);
        check_eq("rst_data_in", 32'(data_in), 32'd0);
        check_eq("rst_ready", 32'(mem_ready), 32'd0);
        check_eq("rst_ce_we", 32'({ram_ce, ram_we}), 32'd0);
        check_eq("rst_ld_ready", 32'(ld_ready), 32'd0);
        check_eq("rst_ld_count", 32'(ld_count), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_addr", 32'(ram_addr), 32'd0);
        check_eq("rst_wdata", 32'(ram_wdata), 32'd0);
        cpustate = 2'b10;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        cpu_access(1'b0, 1'b0, 16'h0012, 8'h00);
        check_eq("read_A5", 32'(data_in), 32'hA5);
        cpu_access(1'b1, 1'b0, 16'h0100, 8'h3C);
        check_eq("wr_keeps_din", 32'(data_in), 32'hA5);
        check_eq("wr_3C", 32'(sram_byte(16'h0100)), 32'h3C);

        for (int t = 0; t < 40; t++) begin
            cpustate = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
            d = 8'($urandom);
            cpu_access($urandom_range(0, 1) != 0, 1'b0, a, d);
        end

        // STOP: nothing is accepted.
        cpustate = 2'b00;
        read = 1'b1; ld_valid = 1'b1;
        hits = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            hits += int'(mem_ready) + int'(ram_ce) + int'(ld_ready);
        end
        read = 1'b0; ld_valid = 1'b0;
        check_eq("stop_idle", 32'(hits), 32'd0);
        check_eq("stop_err", 32'(err), 32'd0);

        enter_load();
        load_byte(8'h11, 0);
        load_byte(8'h22, 1);
        load_byte(8'h33, 1);
        ld_valid = 1'b0;
        @(negedge clk);
        check_eq("ld_count3", 32'(ld_count), 32'd3);
        check_eq("ld_ready_back", 32'(ld_ready), 32'd1);
        for (int i = 0; i < 3; i++)
            check_eq("ld_ram", 32'(sram_byte(16'(i))), 32'(ref_byte(16'(i))));

        cpustate = 2'b10;
        repeat (3) @(negedge clk);
        check_eq("ld_count_hold", 32'(ld_count), 32'd3);
        enter_load();
        for (int i = 0; i < 5; i++) load_byte(8'($urandom), (i == 0) ? 0 : 1);
        ld_valid = 1'b0;
        @(negedge clk);
        check_eq("ld_count_reentry", 32'(ld_count), 32'(ref_cnt));
        for (int i = 0; i < 5; i++)
            check_eq("ld_ram2", 32'(sram_byte(16'(i))), 32'(ref_byte(16'(i))));

        cpustate = 2'b10;
        repeat (2) @(negedge clk);
        cpu_access(1'b1, 1'b1, 16'h0040, 8'h5E);

        // CPU read during LOAD is refused and flagged.
        cpustate = 2'b01;
        read = 1'b1; memaddr = 16'h0012;
        hits = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            hits += int'(mem_ready) + int'(ram_ce);
        end
        read = 1'b0;
        check_eq("load_read_ignored", 32'(hits), 32'd0);
        check_eq("load_read_err", 32'(err), 32'd1);
        cpustate = 2'b10;
        repeat (2) @(negedge clk);

        // Reset pulse while a read sits in RD_WAIT.
        memaddr = 16'h0012; read = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_ce", 32'({ram_ce, ram_we, mem_ready}), 32'd0);
        check_eq("arst_din", 32'(data_in), 32'd0);
        check_eq("arst_err", 32'(err), 32'd0);
        check_eq("arst_cnt", 32'(ld_count), 32'd0);
        read = 1'b0;
        exp_din = 8'h00; exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        hits = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            hits += int'(mem_ready);
        end
        check_eq("arst_no_ready", 32'(hits), 32'd0);
        cpu_access(1'b0, 1'b0, 16'h0040, 8'h00);
        check_eq("read_after_rst", 32'(data_in), 32'h5E);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
